// File: rtl/ext_mem_uart_loader_pkg.sv
// Shared types for the EXT_MEM UART boot loader.
// Sync byte, loader FSM states, UART RX states.
package ext_mem_uart_loader_pkg;

  localparam logic [7:0] LDR_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    DATA,
    CSUM,
    DONE
  } ldr_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/ext_mem_uart_loader_rx.sv
// uart_rx_byte: 8N1 receiver with 2-flop synchronizer.
// Ports: rx_i in; byte_o, byte_vld_o (1 cycle), frame_err_o out.
module uart_rx_byte
  import ext_mem_uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frame_err_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     st, st_nxt;
  logic          s1, s2, s3;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;

  assign byte_o = sh;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) st <= RX_IDLE;
    else         st <= st_nxt;
  end

  // s3 is the previous synchronized sample, for edge detection
  always_comb begin
    st_nxt = st;
    unique case (st)
      RX_IDLE:  if (s3 && !s2) st_nxt = RX_START;
      RX_START: if (cnt == HALF) st_nxt = s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt == FULL && idx == 3'd7) st_nxt = RX_STOP;
      RX_STOP:  if (cnt == FULL) st_nxt = RX_IDLE;
      default:  st_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      {s1, s2, s3} <= 3'b111;
      cnt          <= '0;
      idx          <= '0;
      sh           <= '0;
      byte_vld_o   <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      s1          <= rx_i;
      s2          <= s1;
      s3          <= s2;
      byte_vld_o  <= 1'b0;
      frame_err_o <= 1'b0;
      unique case (st)
        RX_IDLE: begin
          cnt <= '0;
          idx <= '0;
        end
        RX_START: cnt <= (cnt == HALF) ? '0 : cnt + 1'b1;
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt <= '0;
            idx <= idx + 1'b1;
            sh  <= {s2, sh[7:1]};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            cnt         <= '0;
            byte_vld_o  <= s2;
            frame_err_o <= ~s2;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/ext_mem_uart_loader.sv
// UART boot loader + port mux in front of the TCM; optional EXT_MEM_LOADER_CSUM_EN.
// Ports: clk_i rst_ni rx_i, mst_* pass-through, mem_* to TCM, core_hold_o load_done_o load_err_o.
module ext_mem_uart_loader
  import ext_mem_uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = 434,
  parameter logic [31:0] BASE_ADDR     = 32'h1000,
  parameter logic [31:0] MEM_SIZE      = 32'h2_0000,
  parameter int unsigned TIMEOUT_CLKS  = 1_000_000,
  parameter bit          HOLD_AT_RESET = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        rx_i,
  input  logic                        mst_en_i,
  input  logic                        mst_we_i,
  input  logic [3:0]                  mst_be_i,
  input  logic [31:0]                 mst_addr_i,
  input  logic [31:0]                 mst_wdata_i,
  output logic [31:0]                 mst_rdata_o,
  output logic                        mem_en_o,
  output logic                        mem_we_o,
  output logic [3:0]                  mem_be_o,
  output logic [$clog2(MEM_SIZE)-1:0] mem_addr_o,
  output logic [31:0]                 mem_wdata_o,
  input  logic [31:0]                 mem_rdata_i,
  output logic                        core_hold_o,
  output logic                        load_done_o,
  output logic                        load_err_o
);

  localparam int unsigned AW = $clog2(MEM_SIZE);

`ifdef EXT_MEM_LOADER_CSUM_EN
  localparam ldr_state_e END_ST = CSUM;
`else
  localparam ldr_state_e END_ST = DONE;
`endif

  logic [7:0]  rx_byte;
  logic        rx_vld, rx_ferr;
  ldr_state_e  state, state_nxt;
  logic [1:0]  bcnt;
  logic [31:0] sh, waddr, off, word, tcnt;
  logic [15:0] nwords;
  logic        wr_pend, timeout;
  logic [AW-1:0] wr_off, mst_off;
  logic [31:0] wr_data;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_i        (rx_i),
    .byte_o      (rx_byte),
    .byte_vld_o  (rx_vld),
    .frame_err_o (rx_ferr)
  );

  // fields arrive LE: shift bytes in from the top
  assign word    = {rx_byte, sh[31:8]};
  assign off     = waddr - BASE_ADDR;
  assign mst_off = AW'(mst_addr_i - BASE_ADDR);
  assign timeout = (state != IDLE) && (tcnt == TIMEOUT_CLKS);
  assign mst_rdata_o = mem_rdata_i;

`ifdef EXT_MEM_LOADER_CSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clk_i) begin
    if (!rst_ni)     csum <= '0;
    else if (rx_vld) csum <= (state == IDLE) ? 8'h00 : csum + rx_byte;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (rx_vld && rx_byte == LDR_SYNC_BYTE) state_nxt = ADDR;
      ADDR: if (rx_vld && bcnt == 2'd3) state_nxt = LEN;
      LEN: begin
        if (rx_vld && bcnt == 2'd1)
          state_nxt = (word[31:16] == 16'd0) ? END_ST : DATA;
      end
      DATA: begin
        if (rx_vld && bcnt == 2'd3 && nwords == 16'd1)
          state_nxt = END_ST;
      end
`ifdef EXT_MEM_LOADER_CSUM_EN
      CSUM: if (rx_vld) state_nxt = (rx_byte == csum) ? DONE : IDLE;
`else
      CSUM: state_nxt = IDLE;
`endif
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bcnt        <= '0;
      sh          <= '0;
      waddr       <= '0;
      nwords      <= '0;
      tcnt        <= '0;
      wr_pend     <= 1'b0;
      wr_off      <= '0;
      wr_data     <= '0;
      load_done_o <= 1'b0;
      load_err_o  <= 1'b0;
    end else begin
      wr_pend <= 1'b0;
      tcnt    <= (state == IDLE || rx_vld) ? '0 : tcnt + 1;
      if (rx_ferr || timeout) load_err_o <= 1'b1;
      if (state == DONE) load_done_o <= 1'b1;
      if (rx_vld) begin
        sh   <= word;
        bcnt <= bcnt + 1'b1;
        unique case (state)
          IDLE: bcnt <= '0;
          ADDR: begin
            if (bcnt == 2'd3) begin
              waddr <= {word[31:2], 2'b00};
              bcnt  <= '0;
            end
          end
          LEN: begin
            if (bcnt == 2'd1) begin
              nwords <= word[31:16];
              bcnt   <= '0;
            end
          end
          DATA: begin
            if (bcnt == 2'd3) begin
              bcnt   <= '0;
              nwords <= nwords - 1'b1;
              waddr  <= waddr + 32'd4;
              // off wraps huge below BASE_ADDR, so one compare covers both ends
              if (off < MEM_SIZE) begin
                wr_pend <= 1'b1;
                wr_off  <= off[AW-1:0];
                wr_data <= word;
              end else begin
                load_err_o <= 1'b1;
              end
            end
          end
`ifdef EXT_MEM_LOADER_CSUM_EN
          CSUM: if (rx_byte != csum) load_err_o <= 1'b1;
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    mem_en_o    = wr_pend;
    mem_we_o    = wr_pend;
    mem_be_o    = 4'hF;
    mem_addr_o  = wr_off;
    mem_wdata_o = wr_data;
    core_hold_o = (state != DONE);
    if (state == IDLE) begin
      mem_en_o    = mst_en_i;
      mem_we_o    = mst_we_i;
      mem_be_o    = mst_be_i;
      mem_addr_o  = mst_off;
      mem_wdata_o = mst_wdata_i;
      core_hold_o = HOLD_AT_RESET && !load_done_o;
    end
  end

endmodule
